// File: rtl/cache_arbiter_rr_pkg.sv
// Shared types for the round-robin cache bank arbiter.
//   InPortIdx / OutPortIdx / BankIdx : index types, wide enough for up to
//                                      16 requesters, SRAM ports or banks
//   ReadTag                          : in-flight read record {valid, bank, port}
//   cache_req_t                      : typical request layout, used as the
//                                      default request type of the arbiter
//   next_ptr()                       : round-robin pointer advance with wrap
package cache_arbiter_rr_pkg;

    localparam int IDX_W = 4;

    typedef logic [IDX_W-1:0] InPortIdx;
    typedef logic [IDX_W-1:0] OutPortIdx;
    typedef logic [IDX_W-1:0] BankIdx;

    typedef struct packed {
        logic      valid;
        BankIdx    bank;
        OutPortIdx port;
    } ReadTag;

    // ce and we are active-low.
    typedef struct packed {
        logic        ce;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } cache_req_t;

    // Index following the last granted requester, wrapping at n.
    function automatic InPortIdx next_ptr(input InPortIdx last, input int n);
        return (int'(last) + 1 >= n) ? '0 : last + 1'b1;
    endfunction

endpackage

// File: rtl/RoundRobinPicker.sv
// Picks up to OUTPUT_PORTS requesters from a unary request vector, scanning
// in round-robin order starting at ptr.
//   req        : one bit per requester
//   ptr        : first requester index to consider
//   pick_idx   : k-th granted requester index
//   pick_valid : pick_idx[k] is a real grant
//   last_idx   : index of the last granted requester (valid when pick_valid[0])
module RoundRobinPicker
    import cache_arbiter_rr_pkg::*;
#(
    parameter int INPUT_PORTS  = 4,
    parameter int OUTPUT_PORTS = 2
) (
    input  logic [INPUT_PORTS-1:0]  req,
    input  InPortIdx                ptr,
    output InPortIdx                pick_idx [OUTPUT_PORTS],
    output logic [OUTPUT_PORTS-1:0] pick_valid,
    output InPortIdx                last_idx
);

    always_comb begin
        int   n_grant;
        int   cand;
        logic hit;
        // NOTE: every output gets a default before the scan so that no path
        // leaves a value unassigned, which would otherwise infer a latch.
        for (int k = 0; k < OUTPUT_PORTS; k++) pick_idx[k] = '0;
        pick_valid = '0;
        last_idx   = '0;
        n_grant    = 0;
        for (int off = 0; off < INPUT_PORTS; off++) begin
            cand = int'(ptr) + off;
            if (cand >= INPUT_PORTS) cand = cand - INPUT_PORTS;
            hit = 1'b0;
            for (int i = 0; i < INPUT_PORTS; i++)
                if (i == cand) hit = req[i];
            if (hit && n_grant < OUTPUT_PORTS) begin
                // Constant-indexed write keeps the slot selection a plain mux.
                for (int k = 0; k < OUTPUT_PORTS; k++) begin
                    if (k == n_grant) begin
                        pick_idx[k]   = InPortIdx'(cand);
                        pick_valid[k] = 1'b1;
                    end
                end
                last_idx = InPortIdx'(cand);
                n_grant++;
            end
        end
    end

endmodule

// File: rtl/cache_arbiter_rr.sv
// Round-robin arbiter from INPUT_PORTS requesters onto OUTPUT_BANKS banks of
// OUTPUT_PORTS SRAM ports each, with read-data return routing.
//   clk, rst        : clock, synchronous active-high reset
//   IN_ports        : requests (active when ce=0, read when we=1)
//   OUT_portReady   : request granted this cycle (combinational)
//   OUT_portRValid  : read data valid for the requester this cycle
//   OUT_portRData   : returned read data (don't-care when RValid=0)
//   OUT_ports       : per bank/port command, ce=1 when unused
//   IN_portRData    : bank read data, READ_LAT cycles after the command
//   IN_bankStall    : bank accepts no command this cycle
module cache_arbiter_rr
    import cache_arbiter_rr_pkg::*;
#(
    parameter int  INPUT_PORTS  = 4,
    parameter int  OUTPUT_PORTS = 2,
    parameter int  OUTPUT_BANKS = 4,
    parameter int  BANK_OFFSET  = 0,
    parameter int  DATA_WIDTH   = 32,
    parameter int  READ_LAT     = 2,
    parameter type IF_t         = cache_req_t
) (
    input  logic                   clk,
    input  logic                   rst,
    input  IF_t                    IN_ports       [INPUT_PORTS],
    output logic [INPUT_PORTS-1:0] OUT_portReady,
    output logic [INPUT_PORTS-1:0] OUT_portRValid,
    output logic [DATA_WIDTH-1:0]  OUT_portRData  [INPUT_PORTS],
    output IF_t                    OUT_ports      [OUTPUT_BANKS][OUTPUT_PORTS],
    input  logic [DATA_WIDTH-1:0]  IN_portRData   [OUTPUT_BANKS][OUTPUT_PORTS],
    input  logic [OUTPUT_BANKS-1:0] IN_bankStall
);

    localparam int BANK_W = (OUTPUT_BANKS > 1) ? $clog2(OUTPUT_BANKS) : 1;

    BankIdx                  bank_sel   [INPUT_PORTS];
    logic [INPUT_PORTS-1:0]  bank_req   [OUTPUT_BANKS];
    InPortIdx                rr_ptr     [OUTPUT_BANKS];
    InPortIdx                pick_idx   [OUTPUT_BANKS][OUTPUT_PORTS];
    logic [OUTPUT_PORTS-1:0] pick_valid [OUTPUT_BANKS];
    InPortIdx                last_idx   [OUTPUT_BANKS];
    ReadTag                  grant_tag  [INPUT_PORTS];
    ReadTag                  tag_pipe   [INPUT_PORTS][READ_LAT];

    // Bank decode; a single bank needs no address bits.
    for (genvar i = 0; i < INPUT_PORTS; i++) begin : g_bank_sel
        if (OUTPUT_BANKS > 1) begin : g_multi
            assign bank_sel[i] = BankIdx'(IN_ports[i].addr[BANK_OFFSET +: BANK_W]);
        end else begin : g_single
            assign bank_sel[i] = '0;
        end
    end

    // A stalled bank sees no requests, so it grants nothing and keeps its pointer.
    always_comb begin
        for (int b = 0; b < OUTPUT_BANKS; b++) begin
            for (int i = 0; i < INPUT_PORTS; i++) begin
                bank_req[b][i] = !IN_ports[i].ce && (bank_sel[i] == BankIdx'(b))
                                 && !IN_bankStall[b];
            end
        end
    end

    for (genvar b = 0; b < OUTPUT_BANKS; b++) begin : g_bank
        RoundRobinPicker #(
            .INPUT_PORTS  (INPUT_PORTS),
            .OUTPUT_PORTS (OUTPUT_PORTS)
        ) u_picker (
            .req        (bank_req[b]),
            .ptr        (rr_ptr[b]),
            .pick_idx   (pick_idx[b]),
            .pick_valid (pick_valid[b]),
            .last_idx   (last_idx[b])
        );
    end

    // Grant fan-out: command copy, ready, and the tag that enters the read pipe.
    always_comb begin
        IF_t idle_cmd;
        idle_cmd    = '0;
        idle_cmd.ce = 1'b1;
        idle_cmd.we = 1'b1;
        OUT_portReady = '0;
        for (int i = 0; i < INPUT_PORTS; i++) grant_tag[i] = '0;
        for (int b = 0; b < OUTPUT_BANKS; b++) begin
            for (int k = 0; k < OUTPUT_PORTS; k++) begin
                OUT_ports[b][k] = idle_cmd;
                for (int i = 0; i < INPUT_PORTS; i++) begin
                    if (pick_valid[b][k] && pick_idx[b][k] == InPortIdx'(i)) begin
                        OUT_ports[b][k]    = IN_ports[i];
                        OUT_portReady[i]   = 1'b1;
                        // Writes travel as invalid tags so they never return data.
                        grant_tag[i].valid = IN_ports[i].we;
                        grant_tag[i].bank  = BankIdx'(b);
                        grant_tag[i].port  = OutPortIdx'(k);
                    end
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; the tag shift relies on this ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the tag pipeline is a handful of flops, so it is cleared
            // whole; only the valid bits actually matter after reset.
            for (int i = 0; i < INPUT_PORTS; i++)
                for (int s = 0; s < READ_LAT; s++) tag_pipe[i][s] <= '0;
            for (int b = 0; b < OUTPUT_BANKS; b++) rr_ptr[b] <= '0;
        end else begin
            for (int i = 0; i < INPUT_PORTS; i++) begin
                tag_pipe[i][0] <= grant_tag[i];
                for (int s = 1; s < READ_LAT; s++) tag_pipe[i][s] <= tag_pipe[i][s-1];
            end
            for (int b = 0; b < OUTPUT_BANKS; b++)
                if (pick_valid[b][0]) rr_ptr[b] <= next_ptr(last_idx[b], INPUT_PORTS);
        end
    end

    // Last stage lines up with bank data arriving READ_LAT cycles after the command.
    always_comb begin
        OUT_portRValid = '0;
        for (int i = 0; i < INPUT_PORTS; i++) begin
            OUT_portRValid[i] = tag_pipe[i][READ_LAT-1].valid;
            OUT_portRData[i]  = '0;
            for (int b = 0; b < OUTPUT_BANKS; b++)
                for (int p = 0; p < OUTPUT_PORTS; p++)
                    if (tag_pipe[i][READ_LAT-1].bank == BankIdx'(b)
                        && tag_pipe[i][READ_LAT-1].port == OutPortIdx'(p))
                        OUT_portRData[i] = IN_portRData[b][p];
        end
    end

endmodule
